// File: rtl/lisnoc_wormhole_arbiter_pkg.sv
// Shared lisnoc flit definitions.
// Flit type codes live in the MSBs of every flit.
package lisnoc_wormhole_arbiter_pkg;

   localparam int FLIT_TYPE_W = 2;

   typedef enum logic [FLIT_TYPE_W-1:0] {
      FLIT_PAYLOAD = 2'b00,
      FLIT_HEADER  = 2'b01,
      FLIT_LAST    = 2'b10,
      FLIT_SINGLE  = 2'b11
   } flit_type_e;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_e;

   // Only these types may open a packet.
   function automatic logic is_head(
      input logic [FLIT_TYPE_W-1:0] t
   );
      return (t == FLIT_HEADER) || (t == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/lisnoc_wormhole_arbiter_if.sv
// Flit channel bundle between requesters,
// arbiter and the downstream consumer.
interface lisnoc_wormhole_arbiter_if #(
   parameter int flit_width = 34,
   parameter int PORTS      = 5
);
   localparam int OW = $clog2(PORTS);

   logic [PORTS*flit_width-1:0] in_flit;
   logic [PORTS-1:0]            in_valid;
   logic [PORTS-1:0]            in_ready;
   logic [flit_width-1:0]       out_flit;
   logic                        out_valid;
   logic                        out_ready;
   logic                        locked;
   logic [OW-1:0]               owner;

   modport master (
      output in_flit, in_valid, out_ready,
      input  in_ready, out_flit, out_valid,
      input  locked, owner
   );

   modport slave (
      input  in_flit, in_valid, out_ready,
      output in_ready, out_flit, out_valid,
      output locked, owner
   );

endinterface

// File: rtl/lisnoc_rr_pick.sv
// Rotate-priority picker: first request at or
// after ptr_i, wrapping modulo PORTS.
module lisnoc_rr_pick #(
   parameter  int PORTS = 5,
   localparam int IW    = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [PORTS-1:0] gnt_o,
   output logic [IW-1:0]    idx_o,
   output logic             any_o
);

   // Scan from the pointer; first hit wins.
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
         j = int'(ptr_i) + k;
         if (j >= PORTS) j = j - PORTS;
         if (!any_o && j < PORTS && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/lisnoc_wormhole_arbiter.sv
// Wormhole output-port arbiter: per-packet lock,
// round-robin between packets, registered output.
import lisnoc_wormhole_arbiter_pkg::*;

module lisnoc_wormhole_arbiter #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int PORTS           = 5
) (
   input logic clk,
   input logic rst,
   lisnoc_wormhole_arbiter_if.slave bus
);

   localparam int flit_width =
      flit_data_width + flit_type_width;
   localparam int IW = $clog2(PORTS);

   arb_state_e            state_q, state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [flit_width-1:0] out_flit_q, out_flit_d;
   logic                  out_valid_q, out_valid_d;

   logic [flit_type_width-1:0] ftype [PORTS];
   logic [PORTS-1:0]      elig;
   logic [PORTS-1:0]      pick_gnt;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;
   logic [PORTS-1:0]      owner_oh;
   logic [PORTS-1:0]      in_ready_w;
   logic [IW-1:0]         sel_idx;
   logic [flit_width-1:0] sel_flit;
   logic [flit_type_width-1:0] sel_type;
   logic                  load;
   logic                  xfer;

   function automatic logic [IW-1:0] wrap_inc(
      input logic [IW-1:0] v
   );
      return (v == IW'(PORTS - 1)) ? '0 : v + IW'(1);
   endfunction

   for (genvar i = 0; i < PORTS; i++) begin : g_type
      assign ftype[i] = bus.in_flit[
         i*flit_width + flit_data_width
         +: flit_type_width];
      assign elig[i] = bus.in_valid[i] &
                       is_head(ftype[i]);
   end

   lisnoc_rr_pick #(
      .PORTS (PORTS)
   ) u_pick (
      .req_i (elig),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign load     = !out_valid_q | bus.out_ready;
   assign owner_oh = PORTS'(1) << owner_q;
   assign sel_idx  = (state_q == ST_LOCKED) ?
                     owner_q : pick_idx;
   assign sel_flit = bus.in_flit[
      int'(sel_idx)*flit_width +: flit_width];
   assign sel_type = sel_flit[
      flit_width-1 -: flit_type_width];
   assign xfer     = |(bus.in_valid & in_ready_w);

   // Grant: owner while locked, else the RR pick.
   always_comb begin
      in_ready_w = '0;
      if (load) begin
         if (state_q == ST_LOCKED)
            in_ready_w = owner_oh;
         else if (pick_any)
            in_ready_w = pick_gnt;
      end
   end

   // Lock FSM next state, pointer and owner.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               owner_d = pick_idx;
               if (sel_type == FLIT_HEADER)
                  state_d = ST_LOCKED;
               else
                  rr_ptr_d = wrap_inc(pick_idx);
            end
         end
         ST_LOCKED: begin
            if (xfer && sel_type == FLIT_LAST) begin
               state_d  = ST_IDLE;
               rr_ptr_d = wrap_inc(owner_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register: load on push, clear on pop.
   always_comb begin
      out_flit_d  = out_flit_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_flit_d  = sel_flit;
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_flit  = out_flit_q;
   assign bus.out_valid = out_valid_q;
   assign bus.locked    = (state_q == ST_LOCKED);
   assign bus.owner     = owner_q;

endmodule

// File: doc/lisnoc_wormhole_arbiter.md
# lisnoc_wormhole_arbiter

Output-port arbiter that shares one downstream flit channel between `PORTS` upstream FIFOs (the router's per-direction input buffers). It grants one requester per packet, locks the channel until that packet's last flit is forwarded (wormhole switching), and rotates priority round-robin between packets. A one-entry output register decouples the downstream handshake from the arbitration path.

## Interface
Parameters:
- `flit_data_width`, 32, payload bits per flit
- `flit_type_width`, 2, type bits per flit; the type field is the flit MSBs
- `PORTS`, 5, number of requesters (≥2)
- local `flit_width` = `flit_data_width`+`flit_type_width`

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_flit`  in  `PORTS*flit_width`  requester flits; port i occupies bits [i*flit_width +: flit_width]
- `in_valid`  in  `PORTS`  requester i has a flit at its head
- `in_ready`  out  `PORTS`  flit of requester i is accepted this cycle
- `out_flit`  out  `flit_width`  registered output flit
- `out_valid`  out  1  `out_flit` holds data
- `out_ready`  in  1  downstream accepts `out_flit`
- `locked`  out  1  a packet currently owns the channel
- `owner`  out  `$clog2(PORTS)`  current/last granted port

## Operation
- Flit types: PAYLOAD 2'b00, HEADER 2'b01, LAST 2'b10, SINGLE 2'b11.
- Transfers: upstream when `in_valid[i] & in_ready[i]`; downstream when `out_valid & out_ready`.
- `load` = `!out_valid | out_ready`. `in_ready` is one-hot or zero, and is only ever asserted together with `load`.
- **IDLE** (`locked`=0):
  - Eligible requesters: `in_valid[i]` with type HEADER or SINGLE.
  - Pick the first eligible port at or after `rr_ptr`, wrapping modulo `PORTS`. `in_ready[pick]` = `load`.
  - A requester whose head is PAYLOAD or LAST is a protocol error. It is never granted and stays stalled.
- **Accept in IDLE**:
  - HEADER: go to LOCKED with `owner` = pick.
  - SINGLE: stay in IDLE, `rr_ptr` = pick+1 mod `PORTS`, `owner` = pick.
- **LOCKED**:
  - `in_ready[owner]` = `load`, independent of `in_valid`. All other ports get 0.
  - Type is not checked while locked.
  - Accepting LAST: go to IDLE, `rr_ptr` = `owner`+1 mod `PORTS`.
- **Output register**:
  - On an upstream transfer, `out_flit` ← selected flit and `out_valid` ← 1.
  - Else on a downstream transfer, `out_valid` ← 0.
  - Else hold.
- **Reset**:
  - State IDLE, `rr_ptr` 0, `owner` 0.
  - `out_valid` 0, `out_flit` 0, `locked` 0.
  - `in_ready` all 0 until a valid header appears.
  - Reset mid-packet drops the lock and any flit held in the output register; no flit is emitted afterwards.

## Timing
- Latency: an accepted flit appears on `out_flit` the next cycle.
- Throughput: 1 flit/cycle with `out_ready` held high.
- Back-to-back packets have no bubble. The cycle after LAST is accepted, the IDLE pick can already be accepted when `load`=1.
- With `out_ready`=0 and `out_valid`=1, every `in_ready` is 0 and all state holds.
- A simultaneous downstream pop and upstream push in one cycle is legal; the register reloads.
- `in_ready` depends combinationally on `in_valid`/`in_flit` in IDLE and on `out_ready`. No combinational path exists from `in_*` to `out_flit`/`out_valid`.

## Structure
- Flit type constants and the flit type/data field slicing belong in the shared lisnoc definitions header, the same one the FIFO uses.
- One sub-module: `lisnoc_rr_pick`. It is a combinational rotate-priority one-hot picker with `PORTS`-bit request, pointer input and one-hot plus index outputs, reusable by other router arbiters.
- Lock FSM, `rr_ptr`, and output register stay in this module.

## Test plan
- Single-port packet: port 2 sends HEADER, PAYLOAD, LAST with `out_ready`=1. Required: three flits in order on cycles t+1..t+3, `locked` high for exactly 2 cycles, `rr_ptr`=3 afterwards.
- Contention: ports 0 and 3 present 3-flit packets simultaneously after reset.
  - Port 0's packet goes out completely first, then port 3's, with no interleaving and no bubble.
  - `in_ready[3]` stays 0 until port 0's LAST is accepted.
- Fairness: all 5 ports continuously present SINGLE flits. Required: grant order 0,1,2,3,4,0,… with one flit per cycle.
- Backpressure: mid-packet, hold `out_ready`=0 for 4 cycles. Required: `out_flit` stable, all `in_ready`=0, and the packet resumes intact.
- Protocol error / owner starvation:
  - Port 1 head is PAYLOAD in IDLE: it is never granted, while port 4's HEADER is granted.
  - While locked, owner `in_valid` drops for 3 cycles: no other port is granted.
- Reset mid-packet: assert `rst` after HEADER is accepted. Required: next cycle `out_valid`=0, `locked`=0, and a new HEADER on port 0 is granted.
